// File: rtl/temporal_buffer_drain_if.sv
// temporal_buffer_drain_if: clause stream from the drain sequencer to the clause evaluator.
interface temporal_buffer_drain_if #(
  parameter int NSAT = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int CLAUSE_INDEX_BITS = 5
) ();
  logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_o;
  logic [CLAUSE_INDEX_BITS-1:0] clause_index_o;
  logic valid_o;
  logic ready_i;
  logic last_o;
  modport master (output clause_o, clause_index_o, valid_o, last_o, input ready_i);
  modport slave (input clause_o, clause_index_o, valid_o, last_o, output ready_i);
endinterface

// File: rtl/temporal_buffer_drain.sv
// temporal_buffer_drain: captures one variable's clause bus and streams its occupied slots.
module temporal_buffer_drain #(
  parameter int NSAT = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int NSAT_BITS = 2,
  parameter int CLAUSE_INDEX_BITS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic [NSAT_BITS-1:0] read_index_i,
  output logic [NSAT_BITS-1:0] read_index_o,
  input  logic [NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)-1:0] clause_multi_i,
  input  logic abort_i,
  output logic busy_o,
  output logic done_o,
  output logic [CLAUSE_INDEX_BITS:0] count_o,
  temporal_buffer_drain_if.master dn
);
  localparam int LW = LITERAL_ADDRESS_WIDTH + 1;
  localparam int CW = NSAT * LW;
  localparam int MC = MAX_CLAUSES_PER_VARIABLE;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [NSAT_BITS-1:0] read_index_q, read_index_d;
  logic [CLAUSE_INDEX_BITS:0] count_q, count_d;
  logic [MC-1:0] mask_q, mask_d, occ, low;
  logic [MC*CW-1:0] bus_q, bus_d;
  logic [CLAUSE_INDEX_BITS-1:0] idx;
  logic hs;
  // Null address 0 marks an empty literal; polarity bit never counts toward occupancy.
  always_comb begin
    occ = '0;
    for (int k = 0; k < MC; k++)
      for (int j = 0; j < NSAT; j++)
        occ[k] = occ[k] | (|clause_multi_i[k*CW + j*LW +: LITERAL_ADDRESS_WIDTH]);
  end
  always_comb begin
    idx = '0;
    for (int k = MC - 1; k >= 0; k--)
      if (mask_q[k]) idx = CLAUSE_INDEX_BITS'(k);
  end
  assign low = mask_q & (~mask_q + 1'b1);
  assign dn.valid_o = state_q == STREAM;
  assign dn.last_o = dn.valid_o && (mask_q == low);
  assign dn.clause_index_o = idx;
  assign dn.clause_o = |mask_q ? bus_q[idx*CW +: CW] : '0;
  assign hs = dn.valid_o && dn.ready_i;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign read_index_o = read_index_q;
  assign count_o = count_q;
  always_comb begin
    state_d = state_q;
    read_index_d = read_index_q;
    count_d = count_q;
    mask_d = mask_q;
    bus_d = bus_q;
    case (state_q)
      IDLE: if (start_i) begin
        read_index_d = read_index_i;
        count_d = '0;
        state_d = LOAD;
      end
      LOAD: if (abort_i) begin
        mask_d = '0;
        state_d = IDLE;
      end else begin
        bus_d = clause_multi_i;
        mask_d = occ;
        state_d = |occ ? STREAM : DONE;
      end
      STREAM: begin
        if (hs) begin
          count_d = count_q + 1'b1;
          mask_d = mask_q & ~low;
        end
        if (abort_i) begin
          mask_d = '0;
          state_d = IDLE;
        end else if (hs && dn.last_o) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      read_index_q <= '0;
      count_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      read_index_q <= read_index_d;
      count_q <= count_d;
      mask_q <= mask_d;
    end
    bus_q <= bus_d;
  end
endmodule

// File: doc/temporal_buffer_drain.md
Name: temporal_buffer_drain

Overview:
- Read-side sequencer for the temporal buffer array. It drives the selected flip index into the buffer array and captures the full per-variable clause bus in one cycle.
- It then streams only the occupied clause slots, one clause per cycle, to the downstream clause evaluator over a valid/ready handshake.
- Sits between the heuristic flip selector (start/index source) and the clause evaluation pipeline.

Parameters:
NSAT, 3, literals per clause
LITERAL_ADDRESS_WIDTH, 11, literal address bits; each literal is LITERAL_ADDRESS_WIDTH+1 bits (MSB = polarity)
MAX_CLAUSES_PER_VARIABLE, 20, clause slots per variable on the buffer bus
NSAT_BITS, 2, width of flip index
CLAUSE_INDEX_BITS, 5, width of slot index; must satisfy 2^CLAUSE_INDEX_BITS >= MAX_CLAUSES_PER_VARIABLE

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start_i  in  1  pulse: selected flip is available on read_index_i
read_index_i  in  NSAT_BITS  flip chosen by heuristic selector
read_index_o  out  NSAT_BITS  index driven to buffer array read port
clause_multi_i  in  NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)  clause bus from buffer array; slot k at [k*NSAT*(LAW+1) +: NSAT*(LAW+1)]
abort_i  in  1  drop remaining clauses and return to IDLE
clause_o  out  NSAT*(LITERAL_ADDRESS_WIDTH+1)  current clause
clause_index_o  out  CLAUSE_INDEX_BITS  slot number of clause_o
valid_o  out  1  clause_o valid
ready_i  in  1  downstream accepts clause
last_o  out  1  clause_o is the final occupied slot
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse at end of a normal drain
count_o  out  CLAUSE_INDEX_BITS+1  clauses emitted in the current or most recent drain

Behaviour:
- States: IDLE, LOAD, STREAM, DONE. All state changes occur on the rising clk edge.
- Reset:
  - State goes to IDLE.
  - read_index_o, clause_o, clause_index_o, valid_o, last_o, done_o, count_o and the slot mask all clear to 0.
  - Reset overrides every other input, including when it arrives mid-drain.
- IDLE:
  - On start_i=1, register read_index_i into read_index_o, clear count_o, and go to LOAD.
  - read_index_o holds its value until the next accepted start.
- LOAD:
  - Exactly one cycle; allows for buffer read latency.
  - Capture clause_multi_i into the slot register file.
  - Build an occupancy mask: bit k=1 when any of the NSAT literal address fields (low LAW bits) in slot k is nonzero. Address 0 is reserved as null; the polarity bit is ignored for occupancy.
  - If the mask is nonzero, go to STREAM. If it is zero, go to DONE.
- STREAM:
  - valid_o=1.
  - clause_o and clause_index_o come from the lowest set mask bit.
  - last_o=1 when no higher mask bit is set.
  - On valid_o&&ready_i: clear that mask bit and increment count_o. If last_o, go to DONE; otherwise present the next occupied slot in the following cycle with no bubble.
  - While valid_o&&!ready_i, clause_o, clause_index_o and last_o hold stable.
- Latency: start_i at cycle 0 gives first valid_o at cycle 2. Throughput is 1 clause per cycle under continuous ready_i.
- DONE: done_o=1 for one cycle, valid_o=0, then go to IDLE. A start_i seen in DONE is ignored.
- Start handling: start_i is ignored whenever the state is not IDLE (no queuing).
- abort_i:
  - In LOAD or STREAM, go to IDLE next cycle, clear the mask and valid_o, and do not pulse done_o. count_o retains the number of clauses actually accepted.
  - If abort_i and a handshake occur in the same cycle, the handshake counts (count_o increments) and abort takes effect.
  - abort_i is ignored in IDLE and DONE.
- Buffer bus: changes on clause_multi_i after LOAD have no effect on the current drain.

Test Plan:
- Single clause: start_i with read_index_i=2; only slot 7 holds literals {0x005,0x80A,0x003}; ready_i=1 -> read_index_o=2 from cycle 1; one valid beat at cycle 2 with clause_index_o=7 and last_o=1; done_o at cycle 3; count_o=1.
- Full sweep: all 20 slots occupied, ready_i=1 -> 20 back-to-back beats with indices 0..19, last_o only on index 19, count_o=20, done_o one cycle after the last beat.
- Backpressure: slots 3 and 11 occupied; ready_i low for 4 cycles on the first beat -> clause_o and clause_index_o=3 held stable; slot 11 presented the cycle after acceptance.
- Empty and polarity-only: all slots zero except slot 5 set to polarity bits only (0x800) -> no valid_o; done_o at cycle 2; count_o=0.
- Abort mid-stream: slots 0,1,2 occupied; abort_i asserted together with the handshake of slot 1 -> count_o=2, no done_o, busy_o=0 next cycle; a start_i during STREAM before the abort is ignored.
- Reset mid-drain: reset asserted in STREAM -> next cycle all outputs 0 and state IDLE; a subsequent start_i drains normally.
